mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Memory-stage controller that consumes the EX/MEM pipeline register outputs and performs the data-memory access over a req/ack handshake. It resolves branch/jump prediction and drives the MEM/WB register. It stalls upstream stages while a load or store is in flight. It sits between the EX/MEM latch and writeback, and generates the pipeline flush and PC redirect on mispredict.

## Interface
Parameters:
- ACK_TIMEOUT, 16: cycles in WAIT without ack before the access is abandoned; legal range 1..255.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- pc_next4_i  in  32  PC+4 of the instruction in MEM.
- ex_res_i  in  64  ALU result; memory address for loads/stores; branch/jump target in [31:0].
- rr_data2_i  in  64  store data.
- rd_i  in  5  destination register.
- regwrite_i, memread_i, memwrite_i, memtoreg_i  in  1 each  control bits.
- branch_i  in  1  branch resolved taken.
- branch_pre_i  in  1  predicted taken.
- jump_i  in  1  unconditional jump.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  64  address.
- dmem_wdata_o  out  64  store data.
- dmem_rdata_i  in  64  load data; valid with ack.
- dmem_ack_i  in  1  access complete.
- mem_stall_o  out  1  hold IF..EX/MEM this cycle.
- flush_o  out  1  flush IF/ID, ID/EX, EX/MEM this cycle.
- redirect_pc_o  out  32  fetch PC when flush_o is asserted.
- wb_data_o  out  64  MEM/WB write data.
- wb_rd_o  out  5  MEM/WB destination register.
- wb_regwrite_o  out  1  MEM/WB write enable.
- mem_err_o  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, WAIT.
- IDLE, memread_i|memwrite_i = 0:
  - Instruction retires this cycle; no stall.
- IDLE, access pending:
  - Capture address, wdata, we, rd, regwrite, memtoreg, pc_next4 into internal registers.
  - dmem_req_o = 1 combinationally from the inputs.
  - If dmem_ack_i is high the same cycle, retire (zero-wait access).
  - Otherwise assert mem_stall_o and go to WAIT.
- WAIT:
  - dmem_req_o, dmem_we_o, dmem_addr_o and dmem_wdata_o are driven from the captured registers.
  - Stable until ack; mem_stall_o = 1.
  - Ack: retire, go to IDLE, stall drops the same cycle.
  - Timeout counter reaches ACK_TIMEOUT with no ack: drop req, set mem_err_o, retire with regwrite suppressed, go to IDLE.
  - Ack in the timeout cycle: ack wins, no error.
- Writeback select:
  - memtoreg → dmem_rdata_i (captured on ack).
  - jump_i → zero-extended pc_next4.
  - Otherwise → ex_res_i.
- Misprediction, evaluated only for non-memory instructions in IDLE:
  - taken = branch_i|jump_i.
  - flush_o = taken ^ branch_pre_i.
  - redirect_pc_o = taken ? ex_res_i[31:0] : pc_next4_i.
  - flush_o = 0 when there is no mispredict; redirect_pc_o is don't-care then.
- Stalled cycle: a bubble (regwrite 0, rd 0, data 0) is written into MEM/WB.
- Simultaneous stall and flush cannot occur: memory instructions never flush.

## Timing
- Reset values:
  - All MEM/WB outputs 0.
  - mem_err_o 0.
  - FSM IDLE, timeout counter 0.
  - dmem_req_o 0, flush_o 0, mem_stall_o 0.
- Latency:
  - Non-memory instruction: MEM/WB outputs update at the next rising edge.
  - Memory instruction with ack after N cycles: stall for N cycles; MEM/WB updates at the edge ending the ack cycle.
- Upstream holds EX/MEM stable while mem_stall_o = 1. The block does not rely on this after capture.
- Reset mid-access: FSM to IDLE, req drops asynchronously, any late ack is ignored.
- mem_err_o clears only on reset.
- Timeout counter: 8 bits; cleared on entry to WAIT; saturates.

## Structure
- Shared package, also used by the pipeline top:
  - FSM state typedef.
  - XLEN = 64, PCW = 32.
  - Reset/bubble constants for MEM/WB fields.
- Sub-module mem_wb_reg: the MEM/WB register with a bubble input and async active-high reset.
- The FSM, timeout counter and mispredict logic stay in mem_stage_ctrl.

## Test plan
- ALU op: ex_res_i=0x1234, regwrite_i=1, rd_i=5 → next edge wb_data_o=0x1234, wb_rd_o=5, wb_regwrite_o=1, no stall.
- Load with ack after 3 cycles: addr 0x80, rdata 0xDEADBEEF → mem_stall_o high 3 cycles, dmem_addr_o=0x80 stable, then wb_data_o=0xDEADBEEF.
- Store with same-cycle ack → dmem_we_o=1, wdata=rr_data2_i, mem_stall_o never high, wb_regwrite_o=0.
- Branch taken, predicted not-taken, ex_res_i[31:0]=0x200 → flush_o=1 for one cycle, redirect_pc_o=0x200. Not taken, predicted taken, pc_next4_i=0x104 → redirect_pc_o=0x104.
- Load with ACK_TIMEOUT=4 and no ack → req drops after 4 WAIT cycles, mem_err_o=1 sticky, wb_regwrite_o=0. Repeat with ack in cycle 4 → no error.
- Assert rst_i during WAIT → dmem_req_o=0 immediately, all outputs 0, next instruction handled normally.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg
// Shared definitions for the memory stage and the pipeline top:
//   - datapath widths (XLEN data, PCW program counter, REGW register index)
//   - FSM state type of the memory-access controller
//   - reset/bubble values for the MEM/WB register fields
//   - pc_to_xlen(): zero-extends a PC value to a full data word
package mem_stage_ctrl_pkg;

    localparam int XLEN = 64;
    localparam int PCW  = 32;
    localparam int REGW = 5;
    localparam int CNTW = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // A bubble is indistinguishable from the reset contents of MEM/WB.
    localparam logic [XLEN-1:0] WB_DATA_BUBBLE     = '0;
    localparam logic [REGW-1:0] WB_RD_BUBBLE       = '0;
    localparam logic            WB_REGWRITE_BUBBLE = 1'b0;

    function automatic logic [XLEN-1:0] pc_to_xlen(input logic [PCW-1:0] pc);
        return {{(XLEN-PCW){1'b0}}, pc};
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_wb_reg.sv
// mem_wb_reg
// MEM/WB pipeline register. Loads a new entry every clock; when bubble_i is
// high the entry written is the bubble (no write, rd 0, data 0).
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   bubble_i                write a bubble instead of the data inputs
//   data_i, rd_i, regwrite_i   entry to capture
//   data_o, rd_o, regwrite_o   registered MEM/WB fields
module mem_wb_reg
    import mem_stage_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [REGW-1:0] rd_i,
    input  logic            regwrite_i,
    output logic [XLEN-1:0] data_o,
    output logic [REGW-1:0] rd_o,
    output logic            regwrite_o
);

    logic [XLEN-1:0] data_reg;
    logic [REGW-1:0] rd_reg;
    logic            regwrite_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_reg     <= WB_DATA_BUBBLE;
            rd_reg       <= WB_RD_BUBBLE;
            regwrite_reg <= WB_REGWRITE_BUBBLE;
        end else if (bubble_i) begin
            data_reg     <= WB_DATA_BUBBLE;
            rd_reg       <= WB_RD_BUBBLE;
            regwrite_reg <= WB_REGWRITE_BUBBLE;
        end else begin
            data_reg     <= data_i;
            rd_reg       <= rd_i;
            regwrite_reg <= regwrite_i;
        end
    end

    assign data_o     = data_reg;
    assign rd_o       = rd_reg;
    assign regwrite_o = regwrite_reg;

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage controller. Takes the EX/MEM register outputs, performs the
// data-memory access over a req/ack handshake, resolves branch/jump
// prediction and feeds the MEM/WB register.
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   pc_next4_i, ex_res_i, rr_data2_i EX/MEM datapath fields
//   rd_i, regwrite_i, memread_i, memwrite_i, memtoreg_i   EX/MEM control
//   branch_i, branch_pre_i, jump_i   branch outcome / prediction / jump
//   dmem_*                           data-memory request/ack interface
//   mem_stall_o                      hold IF..EX/MEM this cycle
//   flush_o, redirect_pc_o           mispredict flush and fetch redirect
//   wb_data_o, wb_rd_o, wb_regwrite_o  MEM/WB register outputs
//   mem_err_o                        sticky access-timeout flag
// Parameter ACK_TIMEOUT (1..255): WAIT cycles without ack before the access
// is abandoned.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [PCW-1:0]  pc_next4_i,
    input  logic [XLEN-1:0] ex_res_i,
    input  logic [XLEN-1:0] rr_data2_i,
    input  logic [REGW-1:0] rd_i,
    input  logic            regwrite_i,
    input  logic            memread_i,
    input  logic            memwrite_i,
    input  logic            memtoreg_i,
    input  logic            branch_i,
    input  logic            branch_pre_i,
    input  logic            jump_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic [XLEN-1:0] dmem_rdata_i,
    input  logic            dmem_ack_i,
    output logic            mem_stall_o,
    output logic            flush_o,
    output logic [PCW-1:0]  redirect_pc_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [REGW-1:0] wb_rd_o,
    output logic            wb_regwrite_o,
    output logic            mem_err_o
);

    localparam logic [CNTW:0] ACK_LIMIT = (CNTW+1)'(ACK_TIMEOUT);

    mem_state_e      state_reg;
    logic [CNTW-1:0] cnt_reg;
    logic            err_reg;

    // Access captured on leaving IDLE, so WAIT does not depend on EX/MEM.
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic            we_reg;
    logic [REGW-1:0] rd_reg;
    logic            regwrite_reg;
    logic            memtoreg_reg;
    logic            jump_reg;
    logic [PCW-1:0]  pc4_reg;

    logic            mem_op;
    logic            taken;
    logic [CNTW:0]   cnt_plus1;
    logic            timeout_hit;

    logic            req_next;
    logic            we_next;
    logic [XLEN-1:0] addr_next;
    logic [XLEN-1:0] wdata_next;
    logic            stall_next;
    logic            flush_next;
    logic [PCW-1:0]  redirect_next;
    logic            bubble_next;
    logic [XLEN-1:0] wb_data_next;
    logic [REGW-1:0] wb_rd_next;
    logic            wb_regwrite_next;

    assign mem_op    = memread_i | memwrite_i;
    assign taken     = branch_i | jump_i;
    assign cnt_plus1 = {1'b0, cnt_reg} + {{CNTW{1'b0}}, 1'b1};

    // The cycle in which the counter would reach ACK_TIMEOUT is the last one
    // the access may complete in; an ack arriving then still wins.
    assign timeout_hit = (state_reg == ST_WAIT) && !dmem_ack_i && (cnt_plus1 >= ACK_LIMIT);

    always_comb begin
        req_next         = 1'b0;
        we_next          = 1'b0;
        addr_next        = '0;
        wdata_next       = '0;
        stall_next       = 1'b0;
        flush_next       = 1'b0;
        redirect_next    = pc_next4_i;
        bubble_next      = 1'b0;
        wb_data_next     = WB_DATA_BUBBLE;
        wb_rd_next       = WB_RD_BUBBLE;
        wb_regwrite_next = WB_REGWRITE_BUBBLE;

        case (state_reg)
            ST_IDLE: begin
                if (mem_op) begin
                    req_next   = 1'b1;
                    we_next    = memwrite_i;
                    addr_next  = ex_res_i;
                    wdata_next = rr_data2_i;
                    if (dmem_ack_i) begin
                        wb_data_next     = memtoreg_i ? dmem_rdata_i :
                                           jump_i     ? pc_to_xlen(pc_next4_i) : ex_res_i;
                        wb_rd_next       = rd_i;
                        wb_regwrite_next = regwrite_i;
                    end else begin
                        stall_next  = 1'b1;
                        bubble_next = 1'b1;
                    end
                end else begin
                    wb_data_next     = jump_i ? pc_to_xlen(pc_next4_i) : ex_res_i;
                    wb_rd_next       = rd_i;
                    wb_regwrite_next = regwrite_i;
                    flush_next       = taken ^ branch_pre_i;
                    redirect_next    = taken ? ex_res_i[PCW-1:0] : pc_next4_i;
                end
            end
            ST_WAIT: begin
                req_next   = 1'b1;
                we_next    = we_reg;
                addr_next  = addr_reg;
                wdata_next = wdata_reg;
                if (dmem_ack_i) begin
                    wb_data_next     = memtoreg_reg ? dmem_rdata_i :
                                       jump_reg     ? pc_to_xlen(pc4_reg) : addr_reg;
                    wb_rd_next       = rd_reg;
                    wb_regwrite_next = regwrite_reg;
                end else if (timeout_hit) begin
                    // Abandoned access retires without touching the register file.
                    wb_rd_next       = rd_reg;
                    wb_regwrite_next = 1'b0;
                end else begin
                    stall_next  = 1'b1;
                    bubble_next = 1'b1;
                end
            end
            default: begin
                bubble_next = 1'b1;
            end
        endcase

        // Reset forces the handshake and pipeline controls low immediately,
        // without waiting for the next edge.
        if (rst_i) begin
            req_next      = 1'b0;
            we_next       = 1'b0;
            addr_next     = '0;
            wdata_next    = '0;
            stall_next    = 1'b0;
            flush_next    = 1'b0;
            redirect_next = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            we_reg       <= 1'b0;
            rd_reg       <= '0;
            regwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
            jump_reg     <= 1'b0;
            pc4_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mem_op) begin
                        addr_reg     <= ex_res_i;
                        wdata_reg    <= rr_data2_i;
                        we_reg       <= memwrite_i;
                        rd_reg       <= rd_i;
                        regwrite_reg <= regwrite_i;
                        memtoreg_reg <= memtoreg_i;
                        jump_reg     <= jump_i;
                        pc4_reg      <= pc_next4_i;
                        if (!dmem_ack_i) begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack_i) begin
                        state_reg <= ST_IDLE;
                    end else if (timeout_hit) begin
                        state_reg <= ST_IDLE;
                        err_reg   <= 1'b1;
                    end else if (cnt_reg != {CNTW{1'b1}}) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bubble_i   (bubble_next),
        .data_i     (wb_data_next),
        .rd_i       (wb_rd_next),
        .regwrite_i (wb_regwrite_next),
        .data_o     (wb_data_o),
        .rd_o       (wb_rd_o),
        .regwrite_o (wb_regwrite_o)
    );

    assign dmem_req_o    = req_next;
    assign dmem_we_o     = we_next;
    assign dmem_addr_o   = addr_next;
    assign dmem_wdata_o  = wdata_next;
    assign mem_stall_o   = stall_next;
    assign flush_o       = flush_next;
    assign redirect_pc_o = redirect_next;
    assign mem_err_o     = err_reg;

endmodule
